datapath_sequencer: RTL and testbench

//  Multi-cycle Moore controller that sequences the register-file / shifter / ALU datapath for one instruction at a time.

---
 rtl/dp_pkg.sv | 62 ++++++
 rtl/datapath_sequencer_if.sv | 35 +++
 rtl/dp_ctrl_decode.sv | 59 +++++
 rtl/datapath_sequencer.sv | 50 +++++
 tb/tb_datapath_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings for the datapath sequencer (opcodes, ALU/vsel codes, states, control bundle)
package dp_pkg;
    localparam int RN_W = 3;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_MOV_IMM = 3'b000;
    localparam logic [OP_W-1:0] OP_MOV_REG = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD     = 3'b010;
    localparam logic [OP_W-1:0] OP_CMP     = 3'b011;
    localparam logic [OP_W-1:0] OP_AND     = 3'b100;
    localparam logic [OP_W-1:0] OP_MVN     = 3'b101;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;
    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_GETA  = 3'd1,
        S_GETB  = 3'd2,
        S_CALC  = 3'd3,
        S_WRREG = 3'd4,
        S_WRIMM = 3'd5,
        S_DONE  = 3'd6
    } state_t;
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RN_W-1:0] rd;
        logic [RN_W-1:0] rn;
        logic [RN_W-1:0] rm;
        logic [1:0]      shift;
    } instr_t;
    typedef struct packed {
        logic            ready;
        logic            done;
        logic            err;
        logic [RN_W-1:0] readnum;
        logic [RN_W-1:0] writenum;
        logic            write;
        logic            loada;
        logic            loadb;
        logic            loadc;
        logic            loads;
        logic            asel;
        logic            bsel;
        logic [1:0]      vsel;
        logic [1:0]      shift;
        logic [1:0]      alu_op;
    } ctrl_t;
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_MVN;
    endfunction
    function automatic logic [1:0] alu_code(input logic [OP_W-1:0] op);
        return op == OP_CMP ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_MVN ? ALU_NOTB : ALU_ADD;
    endfunction
    // First state after accept; A-less ops skip GETA, illegal goes straight to DONE.
    function automatic state_t first_state(input logic [OP_W-1:0] op);
        return op == OP_MOV_IMM ? S_WRIMM :
               (op == OP_MOV_REG || op == OP_MVN) ? S_GETB :
               is_illegal(op) ? S_DONE : S_GETA;
    endfunction
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: instruction handshake from the decoder plus datapath control strobes
interface datapath_sequencer_if;
    import dp_pkg::*;
    logic            start;
    logic [OP_W-1:0] opcode;
    logic [RN_W-1:0] rd;
    logic [RN_W-1:0] rn;
    logic [RN_W-1:0] rm;
    logic [1:0]      shift_in;
    logic            ready;
    logic            done;
    logic            err;
    logic [RN_W-1:0] readnum;
    logic [RN_W-1:0] writenum;
    logic            write;
    logic            loada;
    logic            loadb;
    logic            loadc;
    logic            loads;
    logic            asel;
    logic            bsel;
    logic [1:0]      vsel;
    logic [1:0]      shift;
    logic [1:0]      ALUop;
    modport master (
        output start, opcode, rd, rn, rm, shift_in,
        input  ready, done, err, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop
    );
    modport slave (
        input  start, opcode, rd, rn, rm, shift_in,
        output ready, done, err, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop
    );
endinterface

// File: rtl/dp_ctrl_decode.sv
// dp_ctrl_decode: Moore decode of (state, latched instruction) into strobes and next state
module dp_ctrl_decode
    import dp_pkg::*;
(
    input  state_t          i_state,
    input  instr_t          i_ir,
    input  logic            i_start,
    input  logic [OP_W-1:0] i_op,
    output state_t          o_next,
    output ctrl_t           o_ctrl
);
    // Every strobe defaults to 0 so each state only raises what it uses.
    always_comb begin
        o_next = S_WAIT;
        o_ctrl = '0;
        case (i_state)
            S_WAIT: begin
                o_ctrl.ready = 1'b1;
                o_next       = i_start ? first_state(i_op) : S_WAIT;
            end
            S_GETA: begin
                o_ctrl.readnum = i_ir.rn;
                o_ctrl.loada   = 1'b1;
                o_next         = S_GETB;
            end
            S_GETB: begin
                o_ctrl.readnum = i_ir.rm;
                o_ctrl.loadb   = 1'b1;
                o_next         = S_CALC;
            end
            S_CALC: begin
                o_ctrl.shift  = i_ir.shift;
                o_ctrl.alu_op = alu_code(i_ir.op);
                o_ctrl.asel   = i_ir.op == OP_MOV_REG;
                o_ctrl.loads  = i_ir.op == OP_CMP;
                o_ctrl.loadc  = i_ir.op != OP_CMP;
                o_next        = i_ir.op == OP_CMP ? S_DONE : S_WRREG;
            end
            S_WRREG: begin
                o_ctrl.vsel     = VSEL_C;
                o_ctrl.writenum = i_ir.rd;
                o_ctrl.write    = 1'b1;
                o_next          = S_DONE;
            end
            S_WRIMM: begin
                o_ctrl.vsel     = VSEL_IMM;
                o_ctrl.writenum = i_ir.rd;
                o_ctrl.write    = 1'b1;
                o_next          = S_DONE;
            end
            S_DONE: begin
                o_ctrl.done = 1'b1;
                o_ctrl.err  = is_illegal(i_ir.op);
                o_next      = S_WAIT;
            end
            default: o_next = S_WAIT;
        endcase
    end
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: holds state and instruction registers; strobes come from dp_ctrl_decode
module datapath_sequencer
    import dp_pkg::*;
(
    input logic                 clk,
    input logic                 reset_n,
    datapath_sequencer_if.slave bus
);
    state_t r_state;
    state_t w_next;
    instr_t r_ir;
    ctrl_t  w_ctrl;

    dp_ctrl_decode u_decode (
        .i_state (r_state),
        .i_ir    (r_ir),
        .i_start (bus.start),
        .i_op    (bus.opcode),
        .o_next  (w_next),
        .o_ctrl  (w_ctrl)
    );

    // State advance and instruction capture; the async reset drops straight to WAIT so no strobe survives it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (bus.start && w_ctrl.ready)
                r_ir <= '{op: bus.opcode, rd: bus.rd, rn: bus.rn, rm: bus.rm, shift: bus.shift_in};
        end
    end

    assign bus.ready    = w_ctrl.ready;
    assign bus.done     = w_ctrl.done;
    assign bus.err      = w_ctrl.err;
    assign bus.readnum  = w_ctrl.readnum;
    assign bus.writenum = w_ctrl.writenum;
    assign bus.write    = w_ctrl.write;
    assign bus.loada    = w_ctrl.loada;
    assign bus.loadb    = w_ctrl.loadb;
    assign bus.loadc    = w_ctrl.loadc;
    assign bus.loads    = w_ctrl.loads;
    assign bus.asel     = w_ctrl.asel;
    assign bus.bsel     = w_ctrl.bsel;
    assign bus.vsel     = w_ctrl.vsel;
    assign bus.shift    = w_ctrl.shift;
    assign bus.ALUop    = w_ctrl.alu_op;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed checks of the sequencer driving a behavioural register-file/shifter/ALU datapath
module tb_datapath_sequencer;
    import dp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  imm = 8'h00;
    logic        pre_we = 1'b0;
    logic [2:0]  pre_idx = 3'd0;
    logic [15:0] pre_val = 16'h0;
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc;
    logic        rz;
    logic [15:0] sx, bsh, ain, bin, alu;
    int          checks = 0;
    int          errors = 0;

    datapath_sequencer_if bus ();

    datapath_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Shifter and ALU of the datapath model.
    always_comb begin
        sx  = {{8{imm[7]}}, imm};
        bsh = bus.shift == 2'b01 ? rb << 1 : bus.shift == 2'b10 ? rb >> 1 :
              bus.shift == 2'b11 ? {rb[15], rb[15:1]} : rb;
        ain = bus.asel ? 16'h0 : ra;
        bin = bus.bsel ? sx : bsh;
        alu = bus.ALUop == 2'b00 ? ain + bin : bus.ALUop == 2'b01 ? ain - bin :
              bus.ALUop == 2'b10 ? ain & bin : ~bin;
    end

    // Datapath registers, loaded by the sequencer strobes; pre_we lets the bench seed the register file.
    always @(posedge clk) begin
        if (pre_we) rf[pre_idx] <= pre_val;
        if (bus.loada) ra <= rf[bus.readnum];
        if (bus.loadb) rb <= rf[bus.readnum];
        if (bus.loadc) rc <= alu;
        if (bus.loads) rz <= (alu == 16'h0);
        if (bus.write) rf[bus.writenum] <= bus.vsel == 2'b01 ? sx : rc;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] n,
                         input logic [2:0] m, input logic [1:0] sh);
        bus.opcode   = op;
        bus.rd       = d;
        bus.rn       = n;
        bus.rm       = m;
        bus.shift_in = sh;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    function automatic logic [4:0] strobes();
        return {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, d2, g2, busy_ready;
        logic wr_seen;
        d1 = 0; d2 = 0; g2 = 0; busy_ready = 0; wr_seen = 1'b0;
        bus.start = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.shift_in = '0;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_strobes", strobes(), 0);
        chk("rst_done_err", {bus.done, bus.err}, 0);
        chk("rst_fields", {bus.readnum, bus.writenum, bus.shift, bus.ALUop, bus.vsel}, 0);
        reset_n = 1'b1;
        preload(3'd0, 16'd5);
        preload(3'd1, 16'd7);
        preload(3'd4, 16'd45);
        preload(3'd5, 16'd45);

        // Reset asserted while an ADD sits in GETB.
        issue(OP_ADD, 3'd2, 3'd0, 3'd1, 2'b00);
        chk("t1_geta", strobes(), 5'b10000);
        @(negedge clk);
        chk("t1_getb", strobes(), 5'b01000);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_rst_ready", bus.ready, 1);
        chk("t1_rst_strobes", strobes(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t1_wait_ready", bus.ready, 1);
        chk("t1_wait_strobes", strobes(), 0);

        // MOV_IMM rd=3.
        imm = 8'h2A;
        issue(OP_MOV_IMM, 3'd3, 3'd0, 3'd0, 2'b00);
        chk("t2_c1_ctl", {bus.vsel, 1'b0, bus.writenum}, {2'b01, 1'b0, 3'd3});
        chk("t2_c1_strobes", strobes(), 5'b00001);
        @(negedge clk);
        chk("t2_c2_done", {bus.done, bus.write}, 2'b10);
        @(negedge clk);
        chk("t2_r3", rf[3], 16'h002A);
        chk("t2_ready", bus.ready, 1);

        // ADD rd=2 rn=0 rm=1; inputs are scrambled after accept to prove they were latched.
        issue(OP_ADD, 3'd2, 3'd0, 3'd1, 2'b00);
        bus.rd = 3'd5; bus.rn = 3'd7; bus.rm = 3'd6; bus.opcode = OP_CMP;
        chk("t3_c1", {strobes(), 1'b0, bus.readnum}, {5'b10000, 1'b0, 3'd0});
        @(negedge clk);
        chk("t3_c2", {strobes(), 1'b0, bus.readnum}, {5'b01000, 1'b0, 3'd1});
        @(negedge clk);
        chk("t3_c3", {strobes(), bus.ALUop, bus.asel}, {5'b00100, 2'b00, 1'b0});
        @(negedge clk);
        chk("t3_c4", {strobes(), bus.vsel, bus.writenum}, {5'b00001, 2'b00, 3'd2});
        @(negedge clk);
        chk("t3_c5_done", bus.done, 1);
        chk("t3_r2", rf[2], 16'd12);
        @(negedge clk);

        // CMP rn=4 rm=5, equal operands.
        issue(OP_CMP, 3'd0, 3'd4, 3'd5, 2'b00);
        wr_seen = bus.write;
        @(negedge clk);
        wr_seen |= bus.write;
        @(negedge clk);
        wr_seen |= bus.write;
        chk("t4_calc", {strobes(), bus.ALUop}, {5'b00010, 2'b01});
        @(negedge clk);
        wr_seen |= bus.write;
        chk("t4_done", bus.done, 1);
        chk("t4_z", rz, 1);
        chk("t4_no_write", wr_seen, 0);
        @(negedge clk);

        // MVN rd=6 rm=1, then an illegal opcode.
        preload(3'd1, 16'h00FF);
        issue(OP_MVN, 3'd6, 3'd0, 3'd1, 2'b00);
        chk("t5_c1", {strobes(), 1'b0, bus.readnum}, {5'b01000, 1'b0, 3'd1});
        @(negedge clk);
        chk("t5_c2", {strobes(), bus.ALUop}, {5'b00100, 2'b11});
        @(negedge clk);
        chk("t5_c3", {strobes(), 1'b0, bus.writenum}, {5'b00001, 1'b0, 3'd6});
        @(negedge clk);
        chk("t5_done", bus.done, 1);
        chk("t5_r6", rf[6], 16'hFF00);
        @(negedge clk);
        issue(3'b111, 3'd2, 3'd0, 3'd0, 2'b00);
        chk("t5_ill", {bus.done, bus.err, strobes()}, {2'b11, 5'b00000});
        @(negedge clk);
        chk("t5_ill_after", {bus.ready, bus.done, bus.err}, 3'b100);

        // start held high across two ADDs.
        bus.opcode = OP_ADD; bus.rd = 3'd7; bus.rn = 3'd0; bus.rm = 3'd0; bus.shift_in = 2'b00;
        bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
            end
            if (bus.loada && d1 != 0 && g2 == 0) g2 = i;
            if (i >= 2 && i <= 5 && bus.ready) busy_ready++;
            if (i == 7) bus.start = 1'b0;
        end
        chk("t6_first_done", 16'(d1), 16'd5);
        chk("t6_second_geta", 16'(g2), 16'd7);
        chk("t6_second_done", 16'(d2), 16'd11);
        chk("t6_busy_ready", 16'(busy_ready), 16'd0);
        chk("t6_r7", rf[7], 16'd10);
        chk("t6_idle", bus.ready, 1);

        // start pulsed while busy is ignored.
        imm = 8'h10;
        issue(OP_MOV_IMM, 3'd1, 3'd0, 3'd0, 2'b00);
        bus.opcode = OP_ADD; bus.rd = 3'd3; bus.start = 1'b1;
        @(negedge clk);
        chk("t6b_done", {bus.done, bus.ready}, 2'b10);
        bus.start = 1'b0;
        @(negedge clk);
        chk("t6b_wait", bus.ready, 1);
        @(negedge clk);
        chk("t6b_still_wait", {bus.ready, strobes()}, {1'b1, 5'b00000});
        chk("t6b_r1", rf[1], 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
